sample_extract_ctrl: RTL

// Sequences GLWE->LWE sample extraction for the bootstrapping datapath. Streams all K*N

---
 rtl/sample_extract_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sample_extract_ctrl.sv
// GLWE->LWE sample extraction sequencer: streams mask/body coefficients, remaps them
// negacyclically and writes the LWE BRAM. Define SE_NEGATE_EN to negate wrapped terms.
module sample_extract_ctrl #(
    parameter int unsigned K_PARAM    = 1,
    parameter int unsigned N_PARAM    = 4,
    parameter int unsigned VALUE_SIZE = 32,
    parameter int unsigned READ_LAT   = 2,
    localparam int unsigned GA_W = $clog2((K_PARAM + 1) * N_PARAM),
    localparam int unsigned LA_W = $clog2(K_PARAM * N_PARAM + 1),
    localparam int unsigned H_W  = $clog2(N_PARAM)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic [H_W-1:0]        h_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  glwe_rd_en_out,
    output logic [GA_W-1:0]       glwe_addr_out,
    input  logic [VALUE_SIZE-1:0] glwe_data_in,
    output logic                  lwe_wr_en_out,
    output logic [LA_W-1:0]       lwe_addr_out,
    output logic [VALUE_SIZE-1:0] lwe_data_out
);

    localparam int unsigned DW       = $clog2(READ_LAT + 1);
    localparam int unsigned MaskLast = K_PARAM * N_PARAM - 1;

    typedef enum logic [2:0] {StIdle, StMask, StBody, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [GA_W-1:0] cnt_q, cnt_d;
    logic [H_W-1:0]  h_q, h_d;
    logic [DW-1:0]   drain_q, drain_d;

    logic [READ_LAT-1:0] pv_q;
    logic [READ_LAT-1:0] pneg_q;
    logic [LA_W-1:0]     pidx_q [READ_LAT];

    logic [H_W-1:0]  coef;
    logic [GA_W-1:0] poly_base;
    logic [H_W:0]    off;
    logic            wrap;
    logic [LA_W-1:0] dest;
    logic            neg;
    logic [VALUE_SIZE-1:0] wdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_d     = h_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    state_d = StMask;
                    cnt_d   = '0;
                    h_d     = h_in;
                end
            end
            StMask: begin
                cnt_d = cnt_q + GA_W'(1);
                if (cnt_q == GA_W'(MaskLast)) state_d = StBody;
            end
            StBody: begin
                state_d = StDrain;
                drain_d = '0;
            end
            StDrain: begin
                drain_d = drain_q + DW'(1);
                if (drain_q == DW'(READ_LAT - 1)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Destination index: (h - c) mod N inside poly j, computed one bit wider than h.
    always_comb begin
        coef      = cnt_q[H_W-1:0];
        poly_base = cnt_q & ~GA_W'(N_PARAM - 1);
        wrap      = coef > h_q;
        off       = {1'b0, h_q} - {1'b0, coef} + (wrap ? (H_W+1)'(N_PARAM) : '0);
        if (state_q == StBody) begin
            dest = LA_W'(K_PARAM * N_PARAM);
            neg  = 1'b0;
        end else begin
            dest = LA_W'(poly_base) + LA_W'(off);
            neg  = wrap;
        end
    end

    always_comb begin
        glwe_rd_en_out = (state_q == StMask) || (state_q == StBody);
        glwe_addr_out  = '0;
        if (state_q == StMask) glwe_addr_out = cnt_q;
        else if (state_q == StBody) glwe_addr_out = GA_W'(K_PARAM * N_PARAM) + GA_W'(h_q);
        busy_out = (state_q != StIdle);
        done_out = (state_q == StDone);
    end

`ifdef SE_NEGATE_EN
    assign wdata = pneg_q[READ_LAT-1] ? (~glwe_data_in + VALUE_SIZE'(1)) : glwe_data_in;
`else
    logic unused_neg;
    assign unused_neg = ^pneg_q;
    assign wdata      = glwe_data_in;
`endif

    assign lwe_wr_en_out = pv_q[READ_LAT-1];
    assign lwe_addr_out  = pv_q[READ_LAT-1] ? pidx_q[READ_LAT-1] : '0;
    assign lwe_data_out  = pv_q[READ_LAT-1] ? wdata : '0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            h_q     <= '0;
            drain_q <= '0;
            pv_q    <= '0;
            pneg_q  <= '0;
            for (int i = 0; i < int'(READ_LAT); i++) pidx_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            drain_q <= drain_d;
            for (int i = int'(READ_LAT) - 1; i > 0; i--) begin
                pv_q[i]   <= pv_q[i-1];
                pneg_q[i] <= pneg_q[i-1];
                pidx_q[i] <= pidx_q[i-1];
            end
            pv_q[0]   <= glwe_rd_en_out;
            pneg_q[0] <= neg;
            pidx_q[0] <= dest;
        end
    end

endmodule
